div_iter_unit: RTL and testbench
================================

// Module: div_iter_unit
// PURPOSE
//   Multi-cycle radix-2 restoring divider that replaces the single-cycle '/' and '%' path
//   for DIV/DIVU in the execute stage.
//   EX issues a request with a valid/ready handshake. The unit iterates for 32 cycles, then
//   holds quotient (LO) and remainder (HI) until the pipeline accepts them.
//   EX stalls while busy is high. An exception flush aborts the operation via div_cancel.
// PARAMETERS
//   WIDTH   32   operand/result width; iteration count = WIDTH
// PORTS
//   clk            in   1      clock, all state updates on rising edge
//   resetn         in   1      synchronous active-low reset
//   div_valid      in   1      request present this cycle
//   div_ready      out  1      unit can accept a request (IDLE)
//   div_signed     in   1      1 = DIV (signed), 0 = DIVU
//   div_src1       in   WIDTH  dividend
//   div_src2       in   WIDTH  divisor
//   div_cancel     in   1      flush: abort any operation
//   res_valid      out  1      quotient/remainder valid (DONE)
//   res_ready      in   1      consumer takes result this cycle
//   res_quotient   out  WIDTH  quotient -> LO
//   res_remainder  out  WIDTH  remainder -> HI
//   busy           out  1      request accepted and result not yet consumed (CALC or DONE)
// BEHAVIOUR
//   Reset (resetn=0 at edge): state=IDLE; res_valid=0; res_quotient=0; res_remainder=0;
//     counter=0; busy=0; div_ready=1 from the first cycle after reset.
//   Handshake: accept when div_valid & div_ready. Operands and div_signed are latched at accept;
//     inputs are ignored afterwards.
//   Result handshake: result is consumed when res_valid & res_ready. Outputs are stable while
//     res_valid=1 and res_ready=0.
//   FSM: IDLE -> CALC (accept, divisor!=0) | DONE (accept, divisor==0)
//     CALC -> CALC (counter<WIDTH-1) | DONE (last iteration, sign fix applied in same edge)
//     DONE -> IDLE (res_ready) | DONE (hold)
//     any -> IDLE on div_cancel (highest priority, also over accept in IDLE).
//   Latency: request accepted at cycle T -> res_valid=1 at T+WIDTH+1 (T+33). Divide-by-zero:
//     res_valid at T+1.
//   Throughput: a new request is accepted no earlier than the cycle after DONE->IDLE; DONE never
//     accepts directly.
//   Arithmetic:
//     - signed: divide magnitudes |src1|, |src2| (two's complement negate when bit31=1).
//     - quotient negated iff sign(src1)^sign(src2); remainder takes sign of src1.
//     - unsigned: raw operands, no sign fix.
//     - iteration: partial remainder {rem,quo} shifted left 1. If the upper WIDTH+1-bit trial
//       subtract of the divisor is non-negative, keep the difference and set quotient bit 0 to 1;
//       otherwise restore and set it to 0.
//   Boundary cases:
//     - divisor==0 (both modes): quotient=0, remainder=0.
//     - 0x80000000 / -1 signed: quotient=0x80000000, remainder=0 (wraps, no trap).
//     - |src1| < |src2|: quotient=0, remainder=src1.
//     - cancel in CALC/DONE: next cycle IDLE, res_valid=0, busy=0. res_quotient/res_remainder
//       keep their last value (don't-care). No result is ever presented for a cancelled request.
//     - resetn low mid-operation: same effect as reset, result discarded.
//     - res_ready while res_valid=0: ignored.
// TESTING
//   1. DIVU 100/7: res_valid exactly 33 cycles after accept; quotient=14, remainder=2;
//      div_ready=0 and busy=1 throughout.
//   2. DIV -7/2 (0xFFFFFFF9 / 2): quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
//      DIV 7/-2: quotient=-3, remainder=1.
//   3. Divide by zero, DIV 5/0 and DIVU 0xFFFFFFFF/0: res_valid at T+1; quotient=0,
//      remainder=0.
//   4. DIV 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0. DIVU same operands:
//      quotient=0, remainder=0x80000000.
//   5. Hold res_ready=0 for 10 cycles in DONE: outputs stable, no new accept. Pulse res_ready:
//      IDLE next cycle; back-to-back request then accepted.
//   6. Assert div_cancel at CALC cycle 15, then in the same cycle as div_valid in IDLE: no
//      res_valid ever seen for either request; next request 9/3 returns quotient=3, remainder=0.

Source files
------------

// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// result held in DONE until the consumer takes it; div_cancel aborts at any point.
module div_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  input  logic             div_cancel,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_quotient,
  output logic [WIDTH-1:0] res_remainder,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] res_quotient_q, res_quotient_d;
  logic [WIDTH-1:0] res_remainder_q, res_remainder_d;

  logic             accept;
  logic             last_iter;
  logic             src1_neg, src2_neg;
  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH:0]   cand, trial;
  logic [WIDTH-1:0] step_rem, step_quo;

  assign accept    = div_valid && (state_q == IDLE) && !div_cancel;
  assign last_iter = (count_q == CW'(WIDTH - 1));
  assign src1_neg  = div_signed && div_src1[WIDTH-1];
  assign src2_neg  = div_signed && div_src2[WIDTH-1];
  assign abs1      = src1_neg ? -div_src1 : div_src1;
  assign abs2      = src2_neg ? -div_src2 : div_src2;

  // One restoring step: shift {rem,quo} left, trial-subtract, keep or restore.
  assign cand      = {rem_q, quo_q[WIDTH-1]};
  assign trial     = cand - {1'b0, dsr_q};
  assign step_rem  = trial[WIDTH] ? cand[WIDTH-1:0] : trial[WIDTH-1:0];
  assign step_quo  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (div_src2 == '0) ? DONE : CALC;
      CALC:    if (last_iter) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (div_cancel) state_d = IDLE;
  end

  always_comb begin
    div_ready     = (state_q == IDLE);
    res_valid     = (state_q == DONE);
    busy          = (state_q != IDLE);
    res_quotient  = res_quotient_q;
    res_remainder = res_remainder_q;
  end

  always_comb begin
    count_d         = count_q;
    rem_d           = rem_q;
    quo_d           = quo_q;
    dsr_d           = dsr_q;
    neg_quo_d       = neg_quo_q;
    neg_rem_d       = neg_rem_q;
    res_quotient_d  = res_quotient_q;
    res_remainder_d = res_remainder_q;
    if (accept) begin
      count_d   = '0;
      rem_d     = '0;
      quo_d     = abs1;
      dsr_d     = abs2;
      neg_quo_d = src1_neg ^ src2_neg;
      neg_rem_d = src1_neg;
      if (div_src2 == '0) begin
        res_quotient_d  = '0;
        res_remainder_d = '0;
      end
    end else if (state_q == CALC && !div_cancel) begin
      rem_d   = step_rem;
      quo_d   = step_quo;
      count_d = count_q + 1'b1;
      // Sign fix rides on the final step so DONE presents the finished result.
      if (last_iter) begin
        count_d         = '0;
        res_quotient_d  = neg_quo_q ? -step_quo : step_quo;
        res_remainder_d = neg_rem_q ? -step_rem : step_rem;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q         <= '0;
      rem_q           <= '0;
      quo_q           <= '0;
      dsr_q           <= '0;
      neg_quo_q       <= 1'b0;
      neg_rem_q       <= 1'b0;
      res_quotient_q  <= '0;
      res_remainder_q <= '0;
    end else begin
      count_q         <= count_d;
      rem_q           <= rem_d;
      quo_q           <= quo_d;
      dsr_q           <= dsr_d;
      neg_quo_q       <= neg_quo_d;
      neg_rem_q       <= neg_rem_d;
      res_quotient_q  <= res_quotient_d;
      res_remainder_q <= res_remainder_d;
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: directed vector table, cancel/reset
// sequences, and randomized requests compared against an arithmetic model.
module tb_div_iter_unit;

  logic        clk;
  logic        resetn;
  logic        div_valid;
  logic        div_ready;
  logic        div_signed;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        div_cancel;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_quotient;
  logic [31:0] res_remainder;
  logic        busy;

  int errCount;
  int checkCount;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[12];

  div_iter_unit #(.WIDTH(32)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .div_valid     (div_valid),
    .div_ready     (div_ready),
    .div_signed    (div_signed),
    .div_src1      (div_src1),
    .div_src2      (div_src2),
    .div_cancel    (div_cancel),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_quotient  (res_quotient),
    .res_remainder (res_remainder),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference: MIPS DIV/DIVU semantics from plain arithmetic.
  function automatic void refModel(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  task automatic startReq(input logic s, input logic [31:0] a, input logic [31:0] b);
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    while (div_ready !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("req_ready", {31'b0, div_ready}, 32'd1);
    div_valid  = 1'b1;
    div_signed = s;
    div_src1   = a;
    div_src2   = b;
    res_ready  = 1'b0;
    @(posedge clk);
    #1;
    div_valid  = 1'b0;
    div_signed = 1'($urandom);
    div_src1   = $urandom;
    div_src2   = $urandom;
  endtask

  task automatic applyStimulus(input string nm, input logic s, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                               input int elat, input int hold, input bit pokeReady);
    int lat, bad;
    logic [31:0] cq, cr;
    startReq(s, a, b);
    lat = 1;
    bad = 0;
    while (res_valid !== 1'b1 && lat < 40) begin
      if (div_ready !== 1'b0 || busy !== 1'b1) bad++;
      if (pokeReady) res_ready = 1'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    res_ready = 1'b0;
    cq = res_quotient;
    cr = res_remainder;
    checkOutput({nm, "_latency"}, 32'(lat), 32'(elat));
    checkOutput({nm, "_quotient"}, cq, eq);
    checkOutput({nm, "_remainder"}, cr, er);
    checkOutput({nm, "_busy_during_calc"}, 32'(bad), 32'd0);
    if (hold > 0) begin
      bad        = 0;
      div_valid  = 1'b1;
      div_signed = 1'b0;
      div_src1   = 32'd77;
      div_src2   = 32'd0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        if (res_valid !== 1'b1 || div_ready !== 1'b0 || busy !== 1'b1 ||
            res_quotient !== cq || res_remainder !== cr) bad++;
      end
      div_valid = 1'b0;
      checkOutput({nm, "_hold_unstable"}, 32'(bad), 32'd0);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    checkOutput({nm, "_consumed_valid"}, {31'b0, res_valid}, 32'd0);
    checkOutput({nm, "_consumed_ready"}, {31'b0, div_ready}, 32'd1);
  endtask

  task automatic watchNoResult(input string nm, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (res_valid === 1'b1) seen++;
    end
    checkOutput({nm, "_no_result"}, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] ma, mb, mq, mr;
    logic        ms;
    int          waitCnt;

    errCount   = 0;
    checkCount = 0;
    resetn     = 1'b0;
    div_valid  = 1'b0;
    div_signed = 1'b0;
    div_src1   = 32'd0;
    div_src2   = 32'd0;
    div_cancel = 1'b0;
    res_ready  = 1'b0;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33, 10};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33, 0};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33, 0};
    vecs[3]  = '{1'b1, 32'd5,          32'd0,          32'd0,          32'd0,          1,  0};
    vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd0,          32'd0,          32'd0,          1,  3};
    vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33, 0};
    vecs[6]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33, 0};
    vecs[7]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          33, 0};
    vecs[8]  = '{1'b1, 32'hFFFF_FFFB,  32'd7,          32'd0,          32'hFFFF_FFFB,  33, 0};
    vecs[9]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33, 0};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          33, 0};
    vecs[11] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  33, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkOutput("reset_res_valid", {31'b0, res_valid}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_div_ready", {31'b0, div_ready}, 32'd1);
    checkOutput("reset_quotient", res_quotient, 32'd0);
    checkOutput("reset_remainder", res_remainder, 32'd0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                    vecs[i].q, vecs[i].r, vecs[i].lat, vecs[i].hold, 1'b0);
    end

    // Cancel in CALC cycle 15: no result, unit idle next cycle.
    startReq(1'b0, 32'd1000, 32'd3);
    repeat (14) @(posedge clk);
    @(negedge clk);
    div_cancel = 1'b1;
    @(posedge clk);
    #1;
    div_cancel = 1'b0;
    checkOutput("cancel_calc_valid", {31'b0, res_valid}, 32'd0);
    checkOutput("cancel_calc_busy", {31'b0, busy}, 32'd0);
    checkOutput("cancel_calc_ready", {31'b0, div_ready}, 32'd1);
    watchNoResult("cancel_calc", 40);

    // Cancel together with a request in IDLE: request must be dropped.
    @(negedge clk);
    div_valid  = 1'b1;
    div_cancel = 1'b1;
    div_signed = 1'b0;
    div_src1   = 32'd20;
    div_src2   = 32'd4;
    @(posedge clk);
    #1;
    div_valid  = 1'b0;
    div_cancel = 1'b0;
    checkOutput("cancel_idle_busy", {31'b0, busy}, 32'd0);
    watchNoResult("cancel_idle", 40);
    applyStimulus("after_cancel", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 0, 1'b0);

    // Cancel while holding a result in DONE.
    startReq(1'b0, 32'd50, 32'd5);
    waitCnt = 0;
    while (res_valid !== 1'b1 && waitCnt < 40) begin
      @(posedge clk);
      #1;
      waitCnt++;
    end
    checkOutput("cancel_done_reached", {31'b0, res_valid}, 32'd1);
    @(negedge clk);
    div_cancel = 1'b1;
    @(posedge clk);
    #1;
    div_cancel = 1'b0;
    checkOutput("cancel_done_valid", {31'b0, res_valid}, 32'd0);
    checkOutput("cancel_done_busy", {31'b0, busy}, 32'd0);

    // Reset mid-operation clears results and returns to idle.
    startReq(1'b0, 32'd12345, 32'd11);
    repeat (10) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    checkOutput("midreset_busy", {31'b0, busy}, 32'd0);
    checkOutput("midreset_quotient", res_quotient, 32'd0);
    checkOutput("midreset_remainder", res_remainder, 32'd0);
    watchNoResult("midreset", 40);

    // Randomized requests against the reference model.
    for (int i = 0; i < 25; i++) begin
      ms = 1'($urandom);
      ma = $urandom;
      case ($urandom_range(0, 3))
        0:       mb = 32'd0;
        1:       mb = $urandom_range(1, 16);
        2:       mb = {16'd0, 16'($urandom)};
        default: mb = $urandom;
      endcase
      if (i == 0) begin
        ms = 1'b1;
        ma = 32'h8000_0000;
        mb = 32'hFFFF_FFFF;
      end
      refModel(ms, ma, mb, mq, mr);
      applyStimulus($sformatf("rand%0d", i), ms, ma, mb, mq, mr, (mb == 32'd0) ? 1 : 33,
                    int'($urandom_range(0, 2)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
